// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS-style execute path: default datapath and
// register-specifier widths, and the ALU operation encoding. The ALU and the
// ID/EX pipeline register both import this package so that the opcode values
// carried through the pipeline always agree with what the ALU decodes.
// -----------------------------------------------------------------------------
package mips_pkg;

    // Default datapath width; the ALU is built for 32-bit operands.
    localparam int MIPS_DATA_W = 32;

    // Default register-specifier width (32 architectural registers).
    localparam int MIPS_REG_W  = 5;

    // Width of the ALU control field carried from ID into EX.
    localparam int ALU_CTRL_W  = 4;

    // Width of the shift-amount field.
    localparam int SHAMT_W     = 5;

    // ALU operation encoding shared with the ALU.
    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011
    } alu_op_e;

endpackage : mips_pkg

// File: rtl/forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Operand bypass selection for one EX source operand. Picks between the
// in-flight EX/MEM result, the MEM/WB write-back value, and the value read
// from the register file in ID. The younger EX/MEM producer wins when both
// later stages target the same register. Register 0 is hard-wired to zero in
// the register file, so a write "to" it must never be bypassed.
//
// Ports
//   enable_i           operand slot holds a real instruction; when low the
//                      operand is driven to zero
//   src_i              registered source register specifier
//   reg_data_i         registered register-file read value
//   exmem_reg_write_i  EX/MEM stage will write a register
//   exmem_rd_i         EX/MEM destination register
//   exmem_data_i       EX/MEM ALU result
//   memwb_reg_write_i  MEM/WB stage will write a register
//   memwb_rd_i         MEM/WB destination register
//   memwb_data_i       MEM/WB write-back value
//   fwd_data_o         selected operand value
// -----------------------------------------------------------------------------
module forward_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int REG_W  = MIPS_REG_W
) (
    input  logic              enable_i,
    input  logic [REG_W-1:0]  src_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_W-1:0]  exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_W-1:0]  memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] fwd_data_o
);

    localparam logic [REG_W-1:0]  REG_ZERO  = {REG_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // A producer matches only if it really writes, targets a non-zero
    // register, and that register is the one this operand reads.
    function automatic logic fwd_hit(
        input logic             reg_write,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] src
    );
        return reg_write && (rd != REG_ZERO) && (rd == src);
    endfunction

    logic exmem_hit_s;
    logic memwb_hit_s;

    assign exmem_hit_s = fwd_hit(exmem_reg_write_i, exmem_rd_i, src_i);
    assign memwb_hit_s = fwd_hit(memwb_reg_write_i, memwb_rd_i, src_i);

    // Priority bypass mux: empty slot > EX/MEM > MEM/WB > register file.
    always_comb begin
        fwd_data_o = DATA_ZERO;
        if (!enable_i) begin
            fwd_data_o = DATA_ZERO;
        end else if (exmem_hit_s) begin
            fwd_data_o = exmem_data_i;
        end else if (memwb_hit_s) begin
            fwd_data_o = memwb_data_i;
        end else begin
            fwd_data_o = reg_data_i;
        end
    end

endmodule : forward_unit

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection and EX operand
// forwarding. Decoded ID fields are captured on the rising clock edge and
// presented to EX one cycle later; the ALU operands are then bypassed from
// the EX/MEM and MEM/WB stages combinationally.
//
// Per-edge update priority: reset > flush > stall > load-use bubble > load.
// A bubble clears the valid bit and every control that has a side effect,
// and zeroes the datapath fields as well so that an empty slot is all-zero.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 hold the ID/EX register
//   flush                 turn the next EX slot into a bubble
//   id_*                  decoded instruction fields from ID
//   exmem_*, memwb_*      forwarding sources from later stages
//   ex_data1, ex_data2    ALU operands (data2 is imm when alu_src)
//   ex_store_data         forwarded rt value for stores
//   ex_alu_control,
//   ex_shamt, ex_dest     registered ALU op, shift amount, destination reg
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
//                         registered valid and controls for EX/MEM
//   load_use_hazard       asks IF/ID to hold ID for one cycle
// -----------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int REG_W  = MIPS_REG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_W-1:0]      id_rs,
    input  logic [REG_W-1:0]      id_rt,
    input  logic [REG_W-1:0]      id_rd,
    input  logic [ALU_CTRL_W-1:0] id_alu_control,
    input  logic [SHAMT_W-1:0]    id_shamt,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  exmem_reg_write,
    input  logic [REG_W-1:0]      exmem_rd,
    input  logic [DATA_W-1:0]     exmem_alu_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_W-1:0]      memwb_rd,
    input  logic [DATA_W-1:0]     memwb_write_data,
    output logic [DATA_W-1:0]     ex_data1,
    output logic [DATA_W-1:0]     ex_data2,
    output logic [ALU_CTRL_W-1:0] ex_alu_control,
    output logic [SHAMT_W-1:0]    ex_shamt,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_W-1:0]      ex_dest,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  load_use_hazard
);

    localparam logic [DATA_W-1:0]     DATA_ZERO  = {DATA_W{1'b0}};
    localparam logic [REG_W-1:0]      REG_ZERO   = {REG_W{1'b0}};
    localparam logic [ALU_CTRL_W-1:0] CTRL_ZERO  = {ALU_CTRL_W{1'b0}};
    localparam logic [SHAMT_W-1:0]    SHAMT_ZERO = {SHAMT_W{1'b0}};

    // ---------------------------------------------------------------------
    // ID/EX register fields
    // ---------------------------------------------------------------------
    logic                  valid_q,       valid_d;
    logic [DATA_W-1:0]     rs_data_q,     rs_data_d;
    logic [DATA_W-1:0]     rt_data_q,     rt_data_d;
    logic [DATA_W-1:0]     imm_q,         imm_d;
    logic [REG_W-1:0]      rs_q,          rs_d;
    logic [REG_W-1:0]      rt_q,          rt_d;
    logic [REG_W-1:0]      dest_q,        dest_d;
    logic [ALU_CTRL_W-1:0] alu_control_q, alu_control_d;
    logic [SHAMT_W-1:0]    shamt_q,       shamt_d;
    logic                  alu_src_q,     alu_src_d;
    logic                  reg_write_q,   reg_write_d;
    logic                  mem_read_q,    mem_read_d;
    logic                  mem_write_q,   mem_write_d;
    logic                  mem_to_reg_q,  mem_to_reg_d;

    logic                  hazard_s;
    logic [DATA_W-1:0]     fwd_rs_s;
    logic [DATA_W-1:0]     fwd_rt_s;

    // A load in EX whose target is read by the instruction in ID cannot be
    // bypassed in time; a write to register 0 never creates a dependency.
    always_comb begin
        hazard_s = 1'b0;
        if (valid_q && mem_read_q && (dest_q != REG_ZERO) && id_valid) begin
            hazard_s = (dest_q == id_rs) || (dest_q == id_rt);
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign load_use_hazard = hazard_s;

    // Next-state selection for the ID/EX register. Stall outranks the
    // hazard bubble so a held instruction is never lost; flush outranks
    // stall so a killed slot empties even while the pipe is frozen.
    always_comb begin
        valid_d       = valid_q;
        rs_data_d     = rs_data_q;
        rt_data_d     = rt_data_q;
        imm_d         = imm_q;
        rs_d          = rs_q;
        rt_d          = rt_q;
        dest_d        = dest_q;
        alu_control_d = alu_control_q;
        shamt_d       = shamt_q;
        alu_src_d     = alu_src_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        if (flush || (!stall && (hazard_s || !id_valid))) begin
            // Bubble: everything zero, including don't-care datapath fields.
            valid_d       = 1'b0;
            rs_data_d     = DATA_ZERO;
            rt_data_d     = DATA_ZERO;
            imm_d         = DATA_ZERO;
            rs_d          = REG_ZERO;
            rt_d          = REG_ZERO;
            dest_d        = REG_ZERO;
            alu_control_d = CTRL_ZERO;
            shamt_d       = SHAMT_ZERO;
            alu_src_d     = 1'b0;
            reg_write_d   = 1'b0;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
            mem_to_reg_d  = 1'b0;
        end else if (stall) begin
            // Hold: the defaults above already keep every field.
            valid_d       = valid_q;
        end else begin
            valid_d       = 1'b1;
            rs_data_d     = id_rs_data;
            rt_data_d     = id_rt_data;
            imm_d         = id_imm;
            rs_d          = id_rs;
            rt_d          = id_rt;
            dest_d        = id_reg_dst ? id_rd : id_rt;
            alu_control_d = id_alu_control;
            shamt_d       = id_shamt;
            alu_src_d     = id_alu_src;
            reg_write_d   = id_reg_write;
            mem_read_d    = id_mem_read;
            mem_write_d   = id_mem_write;
            mem_to_reg_d  = id_mem_to_reg;
        end
    end

    // ID/EX register with synchronous reset that discards any held entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= 1'b0;
            rs_data_q     <= DATA_ZERO;
            rt_data_q     <= DATA_ZERO;
            imm_q         <= DATA_ZERO;
            rs_q          <= REG_ZERO;
            rt_q          <= REG_ZERO;
            dest_q        <= REG_ZERO;
            alu_control_q <= CTRL_ZERO;
            shamt_q       <= SHAMT_ZERO;
            alu_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            imm_q         <= imm_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            dest_q        <= dest_d;
            alu_control_q <= alu_control_d;
            shamt_q       <= shamt_d;
            alu_src_q     <= alu_src_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
        end
    end

    // ---------------------------------------------------------------------
    // Operand forwarding, one unit per source operand
    // ---------------------------------------------------------------------
    forward_unit #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_fwd_rs (
        .enable_i          (valid_q),
        .src_i             (rs_q),
        .reg_data_i        (rs_data_q),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_data_i      (exmem_alu_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_data_i      (memwb_write_data),
        .fwd_data_o        (fwd_rs_s)
    );

    forward_unit #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_fwd_rt (
        .enable_i          (valid_q),
        .src_i             (rt_q),
        .reg_data_i        (rt_data_q),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_data_i      (exmem_alu_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_data_i      (memwb_write_data),
        .fwd_data_o        (fwd_rt_s)
    );

    // Second ALU operand: immediate when alu_src, else bypassed rt. The
    // store data path always takes bypassed rt, whatever alu_src says.
    always_comb begin
        ex_data2 = DATA_ZERO;
        if (!valid_q) begin
            ex_data2 = DATA_ZERO;
        end else if (alu_src_q) begin
            ex_data2 = imm_q;
        end else begin
            ex_data2 = fwd_rt_s;
        end
    end

    assign ex_data1       = fwd_rs_s;
    assign ex_store_data  = fwd_rt_s;
    assign ex_alu_control = alu_control_q;
    assign ex_shamt       = shamt_q;
    assign ex_dest        = dest_q;
    assign ex_valid       = valid_q;
    assign ex_reg_write   = reg_write_q;
    assign ex_mem_read    = mem_read_q;
    assign ex_mem_write   = mem_write_q;
    assign ex_mem_to_reg  = mem_to_reg_q;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. Each step drives ID / forwarding inputs,
// pushes the expected EX view onto a scoreboard queue, advances time, then
// pops the expectation and compares every EX output against it.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_alu_control;
    logic [4:0]  id_shamt;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_alu_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_write_data;
    logic [31:0] ex_data1, ex_data2, ex_store_data;
    logic [3:0]  ex_alu_control;
    logic [4:0]  ex_shamt, ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_hazard;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_control(id_alu_control), .id_shamt(id_shamt),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_result(exmem_alu_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_write_data(memwb_write_data),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_alu_control(ex_alu_control),
        .ex_shamt(ex_shamt), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_hazard(load_use_hazard)
    );

    typedef struct {
        logic [31:0] d1, d2, st;
        logic [4:0]  dest;
        logic [3:0]  ctrl;
        logic [4:0]  shamt;
        logic        v, rw, mr, mw, m2r;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_ex(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] st,
                           input logic [4:0] dest, input logic [3:0] ctrl, input logic [4:0] sh,
                           input logic rw, input logic mr, input logic mw, input logic m2r);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.st = st; e.dest = dest; e.ctrl = ctrl; e.shamt = sh;
        e.v = 1'b1; e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r;
        exp_q.push_back(e);
    endtask

    task automatic push_bubble();
        exp_t e;
        e.d1 = 32'h0; e.d2 = 32'h0; e.st = 32'h0; e.dest = 5'd0; e.ctrl = 4'd0; e.shamt = 5'd0;
        e.v = 1'b0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.m2r = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic check_ex(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".data1"}, ex_data1, e.d1);
            chk({tag, ".data2"}, ex_data2, e.d2);
            chk({tag, ".store"}, ex_store_data, e.st);
            chk({tag, ".dest"}, 32'(ex_dest), 32'(e.dest));
            chk({tag, ".ctrl"}, 32'(ex_alu_control), 32'(e.ctrl));
            chk({tag, ".shamt"}, 32'(ex_shamt), 32'(e.shamt));
            chk({tag, ".ctl"}, 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
                32'({e.v, e.rw, e.mr, e.mw, e.m2r}));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [31:0] rs_d, input logic [4:0] rt,
                          input logic [31:0] rt_d, input logic [4:0] rd, input logic [31:0] imm,
                          input logic [3:0] ctrl, input logic [4:0] sh, input logic asrc,
                          input logic rdst, input logic rw, input logic mr, input logic mw,
                          input logic m2r);
        id_valid = 1'b1; id_rs = rs; id_rs_data = rs_d; id_rt = rt; id_rt_data = rt_d;
        id_rd = rd; id_imm = imm; id_alu_control = ctrl; id_shamt = sh; id_alu_src = asrc;
        id_reg_dst = rdst; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
        id_mem_to_reg = m2r;
    endtask

    task automatic clr_fwd();
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_alu_result = 32'h0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_write_data = 32'h0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, ALU_ADD, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
        clr_fwd();

        // Reset state
        push_bubble(); tick(); check_ex("reset");
        chk("reset.hazard", 32'(load_use_hazard), 32'd0);
        reset = 1'b0;

        // Plain ADD: rs=1 (5), rt=2 (7), reg_dst selects rd=4
        set_id(5'd1, 32'h5, 5'd2, 32'h7, 5'd4, 32'h99, ALU_ADD, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_ex(32'h5, 32'h7, 32'h7, 5'd4, ALU_ADD, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_ex("add");

        // SUB rs=1 rt=2, dest=rt; then exercise bypass while holding
        set_id(5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 32'h0, ALU_SUB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push_ex(32'h1, 32'h2, 32'h2, 5'd2, ALU_SUB, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_ex("sub");
        stall = 1'b1;
        exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_alu_result = 32'h10;
        memwb_reg_write = 1'b1; memwb_rd = 5'd1; memwb_write_data = 32'h20;
        push_ex(32'h10, 32'h2, 32'h2, 5'd2, ALU_SUB, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_ex("fwd_exmem");
        exmem_reg_write = 1'b0;
        push_ex(32'h20, 32'h2, 32'h2, 5'd2, ALU_SUB, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_ex("fwd_memwb");
        memwb_rd = 5'd2;
        push_ex(32'h1, 32'h20, 32'h20, 5'd2, ALU_SUB, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_ex("fwd_rt_memwb");
        clr_fwd(); stall = 1'b0;

        // Writes to register 0 are never forwarded
        set_id(5'd0, 32'h33, 5'd0, 32'h44, 5'd6, 32'h0, ALU_AND, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_alu_result = 32'hFFFF;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_write_data = 32'hEEEE;
        push_ex(32'h33, 32'h44, 32'h44, 5'd6, ALU_AND, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_ex("rd0_nofwd");

        // Both stages match rs: EX/MEM wins; MEM/WB alone feeds rt
        set_id(5'd5, 32'h50, 5'd6, 32'h60, 5'd7, 32'h0, ALU_OR, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exmem_rd = 5'd5; exmem_alu_result = 32'hAA;
        memwb_rd = 5'd5; memwb_write_data = 32'hBB;
        push_ex(32'hAA, 32'h60, 32'h60, 5'd7, ALU_OR, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_ex("both_match");
        memwb_rd = 5'd6;
        push_ex(32'hAA, 32'hBB, 32'hBB, 5'd7, ALU_OR, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check_ex("memwb_rt");
        clr_fwd();

        // lw to rt=3 followed by a dependent add -> one bubble
        set_id(5'd6, 32'h100, 5'd3, 32'h77, 5'd0, 32'h8, ALU_ADD, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        push_ex(32'h100, 32'h8, 32'h77, 5'd3, ALU_ADD, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); check_ex("lw");
        set_id(5'd3, 32'h11, 5'd7, 32'h22, 5'd8, 32'h0, ALU_ADD, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("lu.hazard_on", 32'(load_use_hazard), 32'd1);
        push_bubble(); tick(); check_ex("lu_bubble");
        chk("lu.hazard_off", 32'(load_use_hazard), 32'd0);
        push_ex(32'h11, 32'h22, 32'h22, 5'd8, ALU_ADD, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_ex("lu_after");

        // Hazard on rt while stalled: lw stays, no bubble
        set_id(5'd6, 32'h100, 5'd3, 32'h77, 5'd0, 32'h8, ALU_ADD, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        push_ex(32'h100, 32'h8, 32'h77, 5'd3, ALU_ADD, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); check_ex("lw2");
        set_id(5'd7, 32'h1, 5'd3, 32'h2, 5'd9, 32'h0, ALU_SUB, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        #1 chk("lu_rt.hazard", 32'(load_use_hazard), 32'd1);
        push_ex(32'h100, 32'h8, 32'h77, 5'd3, ALU_ADD, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); check_ex("lu_stall_hold");

        // Three stalled cycles with changing ID inputs: EX unchanged
        for (int i = 0; i < 3; i++) begin
            set_id(5'(i + 10), 32'(i * 3 + 1), 5'(i + 20), 32'(i + 100), 5'(i + 1), 32'(i),
                   ALU_OR, 5'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            push_ex(32'h100, 32'h8, 32'h77, 5'd3, ALU_ADD, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
            tick(); check_ex("stall_hold");
        end

        // flush together with stall -> bubble; stall then holds the bubble
        flush = 1'b1;
        push_bubble(); tick(); check_ex("flush_stall");
        flush = 1'b0;
        set_id(5'd1, 32'h9, 5'd2, 32'h9, 5'd3, 32'h0, ALU_ADD, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_bubble(); tick(); check_ex("stall_bubble_hold");
        stall = 1'b0;

        // flush alone kills a valid instruction
        push_ex(32'h9, 32'h9, 32'h9, 5'd3, ALU_ADD, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_ex("pre_flush");
        flush = 1'b1;
        push_bubble(); tick(); check_ex("flush");
        flush = 1'b0;

        // id_valid low loads a bubble
        set_id(5'd4, 32'h4, 5'd5, 32'h5, 5'd6, 32'h0, ALU_ADD, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        id_valid = 1'b0;
        push_bubble(); tick(); check_ex("id_invalid");

        // alu_src with negative imm; store data still takes forwarded rt
        set_id(5'd1, 32'h1, 5'd9, 32'h1234, 5'd0, 32'hFFFFFFFC, ALU_SUB, 5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        memwb_reg_write = 1'b1; memwb_rd = 5'd9; memwb_write_data = 32'h55;
        push_ex(32'h1, 32'hFFFFFFFC, 32'h55, 5'd9, ALU_SUB, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); check_ex("imm_src");
        clr_fwd();

        // Reset in the middle of a stall discards the held instruction
        stall = 1'b1; reset = 1'b1;
        set_id(5'd2, 32'h2, 5'd2, 32'h2, 5'd2, 32'h2, ALU_OR, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        push_bubble(); tick(); check_ex("reset_stall");
        chk("reset_stall.hazard", 32'(load_use_hazard), 32'd0);
        reset = 1'b0; stall = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_id_ex_stage

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 32, datapath width; SHALL be 32 for ALU compatibility.
REQ-002 Parameter REG_W, 5, register-specifier width.
REQ-003 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 stall  in  1  downstream hold: ID/EX register keeps its contents.
REQ-005 flush  in  1  branch/exception kill: next EX slot becomes a bubble.
REQ-006 id_valid  in  1  ID slot holds a real instruction.
REQ-007 id_rs_data, id_rt_data, id_imm  in  DATA_W each  register-file read data; sign-extended immediate.
REQ-008 id_rs, id_rt, id_rd  in  REG_W each  source/destination specifiers.
REQ-009 id_alu_control  in  4  ADD=0000, SUB=0001, AND=0010, OR=0011; id_shamt  in  5.
REQ-010 id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decoded controls.
REQ-011 exmem_reg_write  in  1; exmem_rd  in  REG_W; exmem_alu_result  in  DATA_W  EX/MEM forwarding source.
REQ-012 memwb_reg_write  in  1; memwb_rd  in  REG_W; memwb_write_data  in  DATA_W  MEM/WB forwarding source.
REQ-013 ex_data1, ex_data2  out  DATA_W  ALU operands; ex_alu_control  out  4; ex_shamt  out  5.
REQ-014 ex_store_data  out  DATA_W; ex_dest  out  REG_W; ex_valid  out  1.
REQ-015 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  controls carried to EX/MEM.
REQ-016 load_use_hazard  out  1  request to IF/ID to hold ID for one cycle.

Function
REQ-017 Latency SHALL be one cycle: ID fields sampled at rising clk appear on EX outputs after that edge.
REQ-018 Per-edge priority SHALL be reset > flush > stall > load_use_hazard bubble > normal load.
REQ-019 Bubble SHALL clear ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg; datapath fields don't-care but SHALL be zeroed.
REQ-020 stall SHALL hold every registered field, including a registered bubble.
REQ-021 id_valid=0 on a normal load SHALL load a bubble.
REQ-022 ex_dest SHALL be registered as id_reg_dst ? id_rd : id_rt.
REQ-023 load_use_hazard SHALL be combinational: ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | ex_dest==id_rt).
REQ-024 Forwarding SHALL be combinational on registered rs/rt: EX/MEM match (reg_write & rd!=0 & rd==src) wins over MEM/WB match; else registered register-file value.
REQ-025 Register 0 SHALL never be forwarded; both sources matching SHALL select EX/MEM.
REQ-026 ex_data1 SHALL be forwarded rs; ex_data2 SHALL be id_alu_src-registered ? registered imm : forwarded rt.
REQ-027 ex_store_data SHALL always be forwarded rt, independent of alu_src.
REQ-028 Forwarding SHALL only act when ex_valid=1; with ex_valid=0 operands SHALL be zero.
REQ-029 flush and stall asserted together SHALL produce a bubble.
REQ-030 load_use_hazard asserted with stall SHALL not insert a bubble; the held instruction remains.

Reset
REQ-031 On reset every registered field and every output SHALL be 0 at the next edge; load_use_hazard SHALL be 0.
REQ-032 Reset mid-stall SHALL discard the held instruction.

Structure
REQ-033 ALU opcode constants and DATA_W/REG_W defaults SHALL live in the shared package mips_pkg, shared with the ALU.
REQ-034 Forwarding selection SHALL be one sub-module, forward_unit, instantiated per operand.

Verification
REQ-035 Load add rs=1(0x5),rt=2(0x7),ctrl=0000 -> next cycle ex_data1=0x5, ex_data2=0x7, ex_valid=1.
REQ-036 EX/MEM rd=1 result 0x10, MEM/WB rd=1 data 0x20, ex rs=1 -> ex_data1=0x10; set exmem_reg_write=0 -> 0x20.
REQ-037 EX holds lw to rd=3; ID add rs=3 -> load_use_hazard=1, next edge ex_valid=0, ex_reg_write=0.
REQ-038 stall=1 for 3 cycles with new ID inputs -> EX outputs unchanged; flush+stall -> bubble next edge.
REQ-039 Forward match on rd=0 with result 0xFFFF -> ex_data1 = register-file value, not 0xFFFF.
REQ-040 reset during stall -> all outputs 0 next edge; alu_src=1 imm 0xFFFFFFFC -> ex_data2=0xFFFFFFFC, ex_store_data=forwarded rt.
